input_event_timestamper: RTL and testbench

//  Captures edges on the user_in port into a FIFO and timestamps each one. Timestamps come from a free-running
//  32-bit clk counter. The 68000 reads the records over the system bus. Sits directly upstream of the CPU, on
//  the 0x60xxxx bus select, and raises an interrupt when events are pending. Lets lag tests use hardware-exact

---
 rtl/input_event_timestamper_pkg.sv | 25 ++
 rtl/input_event_timestamper_fifo.sv | 72 +++++++
 rtl/input_event_timestamper.sv | 156 +++++++++++++++
 tb/tb_input_event_timestamper.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_event_timestamper_pkg.sv
// Shared record type, register map and status/control bit positions for the
// input event timestamper.
package timestamper_pkg;

  typedef struct packed {
    logic        vblank;
    logic [6:0]  pins;
    logic [31:0] ts;
  } ts_event_t;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_HEAD   = 2'd1;
  localparam logic [1:0] REG_TS_HI  = 2'd2;
  localparam logic [1:0] REG_TS_LO  = 2'd3;

  localparam int ST_OVERFLOW = 15;
  localparam int ST_EMPTY    = 14;
  localparam int ST_FULL     = 13;
  localparam int ST_IRQ_EN   = 12;

  localparam int CTL_CLR_OVF = 0;
  localparam int CTL_FLUSH   = 1;
  localparam int CTL_IRQ_EN  = 2;

endpackage

// File: rtl/input_event_timestamper_fifo.sv
// Synchronous record FIFO. Flush beats everything; a pop on a full FIFO frees
// the slot that a simultaneous push then reuses, so that push is not dropped.
module ts_event_fifo
  import timestamper_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  ts_event_t           push_data,
  input  logic                pop,
  input  logic                flush,
  output ts_event_t           head,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  ts_event_t             mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = ~|count_q;
  assign full    = count_q[DEPTH_LOG2];
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/input_event_timestamper.sv
// Timestamps edges on user_in into a FIFO readable over the 68000 bus.
// Optional per-bit debounce: define TS_DEBOUNCE_EN.
module input_event_timestamper
  import timestamper_pkg::*;
#(
  parameter int              DEPTH_LOG2      = 4,
  parameter int              IN_W            = 7,
  parameter logic [IN_W-1:0] EDGE_MASK       = IN_W'(7'h7F),
  parameter int              DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] user_in,
  input  logic            vblank,
  input  logic            sel,
  input  logic            rw,
  input  logic [1:0]      ds_n,
  input  logic [1:0]      addr,
  input  logic [15:0]     din,
  output logic [15:0]     dout,
  output logic            irq
);

  logic [31:0]         ts_q, rec_ts;
  logic [IN_W-1:0]     sync1_q, sync2_q, prev_q, level, edges;
  logic                acc, acc_q, acc_rise, wr_ctl, pop, flush, push, drop;
  logic                overflow_q, overflow_d, irq_en_q, irq_en_d, irq_q;
  ts_event_t           push_data, head;
  logic [DEPTH_LOG2:0] count;
  logic                full, empty;
  logic                unused_din;

  assign unused_din = ^din[15:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      ts_q    <= ts_q + 32'd1;
      sync1_q <= user_in;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef TS_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = 1;

  logic [IN_W-1:0] stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q [IN_W];
  logic [DB_W-1:0] db_cnt_d [IN_W];

  // A bit's counter runs only while its synced value disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < IN_W; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < IN_W; i++) db_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < IN_W; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign level  = stable_q;
  assign rec_ts = ts_q - 32'(DEBOUNCE_CYCLES);
`else
  assign level  = sync2_q;
  assign rec_ts = ts_q;
`endif

  assign edges            = (level ^ prev_q) & EDGE_MASK;
  assign push             = |edges;
  assign push_data.vblank = vblank;
  assign push_data.pins   = 7'(level);
  assign push_data.ts     = rec_ts;

  // One bus action per access, taken on the rising edge of the strobe.
  assign acc      = sel & ~&ds_n;
  assign acc_rise = acc & ~acc_q;
  assign wr_ctl   = acc_rise & ~rw & (addr == REG_STATUS) & ~ds_n[0];
  assign pop      = acc_rise & rw & (addr == REG_TS_LO);
  assign flush    = wr_ctl & din[CTL_FLUSH];
  assign drop     = push & full & ~pop & ~flush;

  always_comb begin
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    if (wr_ctl) begin
      irq_en_d = din[CTL_IRQ_EN];
      if (din[CTL_CLR_OVF]) overflow_d = 1'b0;
    end
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= 1'b0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      acc_q      <= acc;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_q & ~empty;
    end
  end

  assign irq = irq_q;

  ts_event_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    dout = '0;
    case (addr)
      REG_STATUS: begin
        dout[ST_OVERFLOW] = overflow_q;
        dout[ST_EMPTY]    = empty;
        dout[ST_FULL]     = full;
        dout[ST_IRQ_EN]   = irq_en_q;
        dout[7:0]         = 8'(count);
      end
      REG_HEAD:  if (!empty) dout = {8'h00, head.vblank, head.pins};
      REG_TS_HI: if (!empty) dout = head.ts[31:16];
      default:   if (!empty) dout = head.ts[15:0];
    endcase
  end

endmodule

// File: tb/tb_input_event_timestamper.sv
// Directed bench for input_event_timestamper: reset, capture timing, overflow,
// register writes, held strobes, full+pop+push, irq timing, flush, debounce.
module tb_input_event_timestamper;
  import timestamper_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  user_in = '0;
  logic        vblank = 1'b0;
  logic        sel = 1'b0;
  logic        rw = 1'b1;
  logic [1:0]  ds_n = 2'b11;
  logic [1:0]  addr = 2'd0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        irq;

  int          tests = 0;
  int          fails = 0;
  int unsigned tb_ts = 0;
  logic [39:0] exp_q[$];

  typedef struct packed {
    logic        rw;
    logic [1:0]  ds_n;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_status;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  input_event_timestamper dut (
    .clk     (clk),
    .reset   (reset),
    .user_in (user_in),
    .vblank  (vblank),
    .sel     (sel),
    .rw      (rw),
    .ds_n    (ds_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .irq     (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic check_status(input string name, input logic [15:0] exp);
    logic [15:0] d;
    peek(REG_STATUS, d);
    check(name, d, exp);
  endtask

  task automatic toggle(input int b);
    logic [39:0] rec;
    user_in[b] = ~user_in[b];
    rec = {vblank, user_in, 32'(tb_ts + 2)};
    if (exp_q.size() < 16) exp_q.push_back(rec);
  endtask

  task automatic bus_op(input logic r, input logic [1:0] a, input logic [15:0] d,
                        input logic [1:0] dsn);
    sel = 1'b1; rw = r; addr = a; din = d; ds_n = dsn;
    tick();
    sel = 1'b0; ds_n = 2'b11; rw = 1'b1;
    tick();
  endtask

  task automatic check_head(input string name);
    logic [15:0] d;
    logic [39:0] rec;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: model queue empty, nothing expected", name);
    end else begin
      rec = exp_q[0];
      peek(REG_HEAD, d);  check({name, "_head"}, d, {8'h00, rec[39:32]});
      peek(REG_TS_HI, d); check({name, "_tshi"}, d, rec[31:16]);
      peek(REG_TS_LO, d); check({name, "_tslo"}, d, rec[15:0]);
    end
  endtask

  task automatic check_head_pop(input string name);
    int sc;
    check_head(name);
    bus_op(1'b1, REG_TS_LO, 16'h0000, 2'b00);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    sc = exp_q.size();
    check_status({name, "_status"}, (sc == 0) ? 16'h4000 : 16'(sc));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      check_head_pop($sformatf("%s%0d", name, i));
  endtask

  initial begin
    logic [15:0] d;

    tbl[0] = '{rw:1'b0, ds_n:2'b01, addr:REG_STATUS, din:16'h0001, exp_status:16'hA010, exp_irq:1'b0};
    tbl[1] = '{rw:1'b0, ds_n:2'b00, addr:REG_HEAD,   din:16'h0007, exp_status:16'hA010, exp_irq:1'b0};
    tbl[2] = '{rw:1'b0, ds_n:2'b00, addr:REG_TS_LO,  din:16'h0007, exp_status:16'hA010, exp_irq:1'b0};
    tbl[3] = '{rw:1'b0, ds_n:2'b00, addr:REG_STATUS, din:16'h0001, exp_status:16'h2010, exp_irq:1'b0};
    tbl[4] = '{rw:1'b0, ds_n:2'b10, addr:REG_STATUS, din:16'h0004, exp_status:16'h3010, exp_irq:1'b1};
    tbl[5] = '{rw:1'b1, ds_n:2'b00, addr:REG_STATUS, din:16'h0000, exp_status:16'h3010, exp_irq:1'b1};
    tbl[6] = '{rw:1'b0, ds_n:2'b00, addr:REG_STATUS, din:16'h0000, exp_status:16'h2010, exp_irq:1'b0};

    // clock/reset
    reset = 1'b1;
    repeat (3) tick();
    tb_ts = 0;
    reset = 1'b0;
    check_status("reset_status", 16'h4000);
    check("reset_irq", irq, 1'b0);
    peek(REG_HEAD, d);  check("reset_head", d, 16'h0000);
    peek(REG_TS_LO, d); check("reset_tslo", d, 16'h0000);

`ifndef TS_DEBOUNCE_EN
    // single edge: pin change while ts=98 is detected in the ts=100 cycle
    while (tb_ts < 98) tick();
    toggle(0);
    tick(); tick();
    check_status("t1_not_yet", 16'h4000);
    tick();
    check_status("t1_count1", 16'h0001);
    check_head_pop("t1");

    // 17 edges into a 16-deep FIFO with vblank set
    vblank = 1'b1;
    for (int i = 0; i < 17; i++) begin
      toggle(1);
      tick();
    end
    repeat (3) tick();
    check_status("t2_full_ovf", 16'hA010);
    check("t2_irq_off", irq, 1'b0);

    for (int i = 0; i < 7; i++) begin
      bus_op(tbl[i].rw, tbl[i].addr, tbl[i].din, tbl[i].ds_n);
      check_status($sformatf("tbl%0d_status", i), tbl[i].exp_status);
      check($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
    end

    // DS held for 10 clocks on the pop register pops once
    check_head("t3_hold");
    sel = 1'b1; rw = 1'b1; addr = REG_TS_LO; ds_n = 2'b00;
    repeat (10) tick();
    sel = 1'b0; ds_n = 2'b11;
    tick();
    void'(exp_q.pop_front());
    check_status("t3_hold_once", 16'h000F);
    drain("t3_drain");
    peek(REG_TS_LO, d);
    check("t3_empty_read", d, 16'h0000);
    bus_op(1'b1, REG_TS_LO, 16'h0000, 2'b00);
    check_status("t3_empty_pop", 16'h4000);

    // full FIFO, new edge lands in the same cycle as the pop strobe edge
    vblank = 1'b0;
    for (int i = 0; i < 16; i++) begin
      toggle(2);
      tick();
    end
    repeat (3) tick();
    check_status("t4_full", 16'h2010);
    begin
      logic [39:0] rec;
      user_in[3] = ~user_in[3];
      rec = {vblank, user_in, 32'(tb_ts + 2)};
      tick(); tick();
      check_head("t4_old_head");
      sel = 1'b1; rw = 1'b1; addr = REG_TS_LO; ds_n = 2'b00;
      tick();
      sel = 1'b0; ds_n = 2'b11;
      void'(exp_q.pop_front());
      exp_q.push_back(rec);
      tick();
    end
    check_status("t4_no_ovf", 16'h2010);
    drain("t4_drain");

    // irq follows non-empty by one clock, in both directions
    bus_op(1'b0, REG_STATUS, 16'h0004, 2'b00);
    check_status("t5_irq_en", 16'h5000);
    toggle(4);
    tick(); tick();
    check("t5_irq_idle", irq, 1'b0);
    tick();
    check_status("t5_count1", 16'h1001);
    check("t5_irq_lag", irq, 1'b0);
    tick();
    check("t5_irq_on", irq, 1'b1);
    check_head("t5_head");
    sel = 1'b1; rw = 1'b1; addr = REG_TS_LO; ds_n = 2'b00;
    tick();
    sel = 1'b0; ds_n = 2'b11;
    void'(exp_q.pop_front());
    check_status("t5_empty", 16'h5000);
    check("t5_irq_still", irq, 1'b1);
    tick();
    check("t5_irq_off", irq, 1'b0);

    // flush in the same cycle as a push discards both stored and incoming
    toggle(5);
    repeat (3) tick();
    check_status("t5_one_left", 16'h1001);
    toggle(6);
    tick(); tick();
    sel = 1'b1; rw = 1'b0; addr = REG_STATUS; din = 16'h0006; ds_n = 2'b00;
    tick();
    sel = 1'b0; ds_n = 2'b11; rw = 1'b1;
    exp_q.delete();
    repeat (4) tick();
    check_status("t5_flushed", 16'h5000);
    check("t5_flush_irq", irq, 1'b0);
`else
    // short pulse is filtered, long pulse gives two records 40 apart
    user_in[2] = 1'b1;
    repeat (10) tick();
    user_in[2] = 1'b0;
    repeat (40) tick();
    check_status("t6_short", 16'h4000);
    exp_q.push_back({1'b0, 7'h04, 32'(tb_ts + 2)});
    exp_q.push_back({1'b0, 7'h00, 32'(tb_ts + 42)});
    user_in[2] = 1'b1;
    repeat (40) tick();
    user_in[2] = 1'b0;
    repeat (60) tick();
    check_status("t6_two", 16'h0002);
    drain("t6_drain");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
